// File: rtl/sata_oob_ctrl.sv
// sata_oob_ctrl: host-side SATA OOB sequencer (COMRESET, COMWAKE, ALIGN bring-up).
// Optional wait-state timeout with automatic retry: define SATA_OOB_CTRL_RETRY_EN.
module sata_oob_ctrl #(
    parameter int unsigned CLKFREQ    = 100_000,
    parameter int unsigned TIMEOUT_US = 880
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic oob_ready,
    output logic oob_cominit,
    output logic oob_comwake,
    output logic oob_oobfinish,
    input  logic det_cominit,
    input  logic det_comwake,
    input  logic rx_align,
    input  logic rx_nonalign,
    output logic tx_d102,
    output logic tx_align,
    output logic linkup,
    output logic timeout
);

    typedef enum logic [3:0] {
        S_COMRESET,
        S_RST_WAIT,
        S_WAIT_INIT,
        S_COMWAKE,
        S_WAKE_WAIT,
        S_WAIT_WAKE,
        S_WAIT_ALIGN,
        S_SEND_ALIGN,
        S_LINKUP
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] na_cnt;
    logic       expired;

`ifdef SATA_OOB_CTRL_RETRY_EN
    localparam int unsigned TMO = CLKFREQ * TIMEOUT_US / 1000;
    localparam int unsigned CW  = $clog2(TMO + 1);

    logic [CW-1:0] wait_cnt;
    logic          in_wait;
    logic          detect;

    assign in_wait = (state == S_WAIT_INIT) || (state == S_WAIT_WAKE) ||
                     (state == S_WAIT_ALIGN);
    // A detection arriving on the last counted cycle still wins over expiry
    assign detect  = ((state == S_WAIT_INIT)  && det_cominit) ||
                     ((state == S_WAIT_WAKE)  && det_comwake) ||
                     ((state == S_WAIT_ALIGN) && rx_align);
    assign expired = in_wait && !detect && (wait_cnt == CW'(TMO - 1));

    // Wait counter restarts on every state change and saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (state_nx != state)
            wait_cnt <= '0;
        else if (in_wait && (wait_cnt != CW'(TMO)))
            wait_cnt <= wait_cnt + CW'(1);
    end
`else
    assign expired = 1'b0;
`endif

    // Next-state selection; restart beats everything, expiry beats normal waits
    always_comb begin
        state_nx = state;
        if (restart) begin
            state_nx = S_COMRESET;
        end else if (expired) begin
            state_nx = S_COMRESET;
        end else begin
            case (state)
                S_COMRESET:   if (oob_ready)   state_nx = S_RST_WAIT;
                S_RST_WAIT:   if (oob_ready)   state_nx = S_WAIT_INIT;
                S_WAIT_INIT:  if (det_cominit) state_nx = S_COMWAKE;
                S_COMWAKE:    if (oob_ready)   state_nx = S_WAKE_WAIT;
                S_WAKE_WAIT:  if (oob_ready)   state_nx = S_WAIT_WAKE;
                S_WAIT_WAKE:  if (det_comwake) state_nx = S_WAIT_ALIGN;
                S_WAIT_ALIGN: if (rx_align)    state_nx = S_SEND_ALIGN;
                S_SEND_ALIGN:
                    if (rx_nonalign && !rx_align && (na_cnt == 2'd2))
                        state_nx = S_LINKUP;
                S_LINKUP:     if (det_cominit) state_nx = S_COMRESET;
                default:                       state_nx = S_COMRESET;
            endcase
        end
    end

    // State register plus the consecutive non-ALIGN counter used in SEND_ALIGN
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_COMRESET;
            na_cnt <= '0;
        end else begin
            state <= state_nx;
            if ((state_nx != state) || rx_align)
                na_cnt <= '0;
            else if ((state == S_SEND_ALIGN) && rx_nonalign)
                na_cnt <= na_cnt + 2'd1;
        end
    end

    // Commands fire only in the cycle the coder accepts them and the state advances
    assign oob_cominit   = (state == S_COMRESET) && oob_ready && !reset && !restart;
    assign oob_comwake   = (state == S_COMWAKE) && oob_ready && !reset && !restart;
    assign tx_d102       = (state == S_WAIT_ALIGN);
    assign tx_align      = (state == S_SEND_ALIGN);
    assign linkup        = (state == S_LINKUP);
    assign oob_oobfinish = (state == S_WAIT_ALIGN) || (state == S_SEND_ALIGN) ||
                           (state == S_LINKUP);
    assign timeout       = expired && !reset;

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// tb_sata_oob_ctrl: randomized self-checking bench for sata_oob_ctrl.
// Expected timelines are derived from the event schedule the bench drives.
module tb_sata_oob_ctrl;

`ifdef SATA_OOB_CTRL_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic restart = 1'b0;
    logic oob_ready = 1'b0;
    logic det_cominit = 1'b0;
    logic det_comwake = 1'b0;
    logic rx_align = 1'b0;
    logic rx_nonalign = 1'b0;
    logic oob_cominit, oob_comwake, oob_oobfinish;
    logic tx_d102, tx_align, linkup, timeout;
    logic [6:0] outs;

    int n_pass = 0;
    int n_total = 0;
    bit rdy[400];

    always #5 clk = ~clk;

    sata_oob_ctrl #(.CLKFREQ(1000), .TIMEOUT_US(100)) dut (
        .clk(clk),
        .reset(reset),
        .restart(restart),
        .oob_ready(oob_ready),
        .oob_cominit(oob_cominit),
        .oob_comwake(oob_comwake),
        .oob_oobfinish(oob_oobfinish),
        .det_cominit(det_cominit),
        .det_comwake(det_comwake),
        .rx_align(rx_align),
        .rx_nonalign(rx_nonalign),
        .tx_d102(tx_d102),
        .tx_align(tx_align),
        .linkup(linkup),
        .timeout(timeout)
    );

    assign outs = {oob_cominit, oob_comwake, oob_oobfinish,
                   tx_d102, tx_align, linkup, timeout};

    function automatic int nr(int s);
        for (int i = s; i < 400; i++)
            if (rdy[i]) return i;
        return 399;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        restart = 1'b0;
        det_cominit = 1'b0;
        det_comwake = 1'b0;
        rx_align = 1'b0;
        rx_nonalign = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic goto_send_align();
        oob_ready = 1'b1;
        tick();
        tick();
        det_cominit = 1'b1;
        tick();
        det_cominit = 1'b0;
        tick();
        tick();
        det_comwake = 1'b1;
        tick();
        det_comwake = 1'b0;
        rx_align = 1'b1;
        tick();
        rx_align = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {restart, oob_ready, det_cominit, det_comwake,
             rx_align, rx_nonalign} = 6'($urandom);
            tick();
            n_total++;
            if (outs !== 7'b0)
                $display("FAIL reset_outs[%0d]: got %b want 0000000", i, outs);
            else n_pass++;
        end
        {restart, det_cominit, det_comwake, rx_align, rx_nonalign} = '0;
        oob_ready = 1'b1;
        reset = 1'b0;
        #1;
        n_total++;
        if (outs !== 7'b1000000)
            $display("FAIL reset_autostart: got %b want 1000000", outs);
        else n_pass++;
        tick();
        n_total++;
        if (outs !== 7'b0)
            $display("FAIL reset_rst_wait: got %b want 0000000", outs);
        else n_pass++;
    endtask

    task automatic test_handshake();
        oob_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            det_comwake = 1'($urandom);
            rx_align = 1'($urandom);
            rx_nonalign = 1'($urandom);
            #1;
            n_total++;
            if (oob_cominit !== 1'b0)
                $display("FAIL hs_hold[%0d]: got %b want 0", i, oob_cominit);
            else n_pass++;
            tick();
        end
        {det_comwake, rx_align, rx_nonalign} = '0;
        oob_ready = 1'b1;
        #1;
        n_total++;
        if (oob_cominit !== 1'b1)
            $display("FAIL hs_accept: got %b want 1", oob_cominit);
        else n_pass++;
        tick();
        n_total++;
        if (oob_cominit !== 1'b0)
            $display("FAIL hs_single: got %b want 0", oob_cominit);
        else n_pass++;
    endtask

    task automatic test_bringup();
        for (int it = 0; it < 4; it++) begin
            int t_ci, t_rw, d1, t_cw, t_ww, d2, a, n1, n2, n3;
            logic [6:0] exp;
            bit d102, tal, lk;
            for (int i = 0; i < 400; i++)
                rdy[i] = (i >= 300) || ($urandom_range(0, 9) < 7);
            t_ci = nr(0);
            t_rw = nr(t_ci + 1);
            d1 = t_rw + 1 + int'($urandom_range(0, 4));
            t_cw = nr(d1 + 1);
            t_ww = nr(t_cw + 1);
            d2 = t_ww + 1 + int'($urandom_range(0, 4));
            a = d2 + 1 + int'($urandom_range(0, 4));
            n1 = a + 1 + int'($urandom_range(0, 2));
            n2 = n1 + 1 + int'($urandom_range(0, 2));
            n3 = n2 + 1 + int'($urandom_range(0, 2));
            do_reset();
            for (int c = 0; c <= n3 + 3; c++) begin
                oob_ready = rdy[c];
                det_cominit = (c == d1);
                det_comwake = (c == d2);
                rx_align = (c == a);
                rx_nonalign = (c == n1) || (c == n2) || (c == n3);
                #1;
                d102 = (c > d2) && (c <= a);
                tal = (c > a) && (c <= n3);
                lk = (c > n3);
                exp = {c == t_ci, c == t_cw, d102 | tal | lk, d102, tal, lk, 1'b0};
                n_total++;
                if (outs !== exp)
                    $display("FAIL bringup[%0d] cyc %0d: got %b want %b",
                             it, c, outs, exp);
                else n_pass++;
                tick();
            end
            {det_cominit, det_comwake, rx_align, rx_nonalign} = '0;
        end
    endtask

    task automatic test_timeout();
        logic [2:0] exp;
        oob_ready = 1'b1;
        do_reset();
        for (int c = 0; c <= 1100; c++) begin
            #1;
            exp[1] = (c == 0) || (RETRY && c >= 102 && (c - 102) % 102 == 0);
            exp[0] = RETRY && c >= 101 && (c - 101) % 102 == 0;
            n_total++;
            if ({oob_cominit, timeout} !== exp[1:0])
                $display("FAIL tmo_init cyc %0d: got %b%b want %b",
                         c, oob_cominit, timeout, exp[1:0]);
            else n_pass++;
            tick();
        end
        do_reset();
        for (int c = 0; c <= 206; c++) begin
            det_cominit = (c == 101);
            #1;
            exp = {(c == 0) || (RETRY && c == 204), c == 102, RETRY && c == 203};
            n_total++;
            if ({oob_cominit, oob_comwake, timeout} !== exp)
                $display("FAIL tmo_detect_wins cyc %0d: got %b%b%b want %b",
                         c, oob_cominit, oob_comwake, timeout, exp);
            else n_pass++;
            tick();
        end
        det_cominit = 1'b0;
    endtask

    task automatic test_align_filter();
        for (int it = 0; it < 4; it++) begin
            bit ev[$];
            int k;
            ev.delete();
            if (it == 0) begin
                ev = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            end else begin
                int len = int'($urandom_range(3, 8));
                for (int i = 0; i < len; i++)
                    ev.push_back($urandom_range(0, 2) == 0);
                repeat (3) ev.push_back(1'b0);
            end
            k = ev.size() - 1;
            for (int i = ev.size() - 1; i >= 2; i--)
                if (!ev[i] && !ev[i-1] && !ev[i-2]) k = i;
            do_reset();
            goto_send_align();
            for (int j = 0; j <= k; j++) begin
                int gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    #1;
                    n_total++;
                    if ({tx_align, linkup, tx_d102} !== 3'b100)
                        $display("FAIL align_idle[%0d] ev %0d: got %b want 100",
                                 it, j, {tx_align, linkup, tx_d102});
                    else n_pass++;
                    tick();
                end
                rx_align = ev[j];
                rx_nonalign = !ev[j];
                #1;
                n_total++;
                if ({tx_align, linkup, tx_d102} !== 3'b100)
                    $display("FAIL align_ev[%0d] ev %0d: got %b want 100",
                             it, j, {tx_align, linkup, tx_d102});
                else n_pass++;
                tick();
                rx_align = 1'b0;
                rx_nonalign = 1'b0;
            end
            #1;
            n_total++;
            if ({tx_align, linkup, tx_d102} !== 3'b010)
                $display("FAIL align_linkup[%0d]: got %b want 010",
                         it, {tx_align, linkup, tx_d102});
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        do_reset();
        goto_send_align();
        rx_nonalign = 1'b1;
        repeat (3) tick();
        rx_nonalign = 1'b0;
        #1;
        n_total++;
        if (linkup !== 1'b1)
            $display("FAIL restart_pre_linkup: got %b want 1", linkup);
        else n_pass++;
        restart = 1'b1;
        rx_align = 1'b1;
        tick();
        restart = 1'b0;
        rx_align = 1'b0;
        #1;
        n_total++;
        if ({linkup, tx_align, oob_oobfinish, oob_cominit} !== 4'b0001)
            $display("FAIL restart_override: got %b want 0001",
                     {linkup, tx_align, oob_oobfinish, oob_cominit});
        else n_pass++;
        tick();
        n_total++;
        if (outs !== 7'b0)
            $display("FAIL restart_rst_wait: got %b want 0000000", outs);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        oob_ready = 1'b1;
        do_reset();
        tick();
        tick();
        det_cominit = 1'b1;
        tick();
        det_cominit = 1'b0;
        tick();
        tick();
        det_comwake = 1'b1;
        tick();
        det_comwake = 1'b0;
        #1;
        n_total++;
        if (outs !== 7'b0011000)
            $display("FAIL midrst_wait_align: got %b want 0011000", outs);
        else n_pass++;
        reset = 1'b1;
        oob_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (outs !== 7'b0)
                $display("FAIL midrst_held[%0d]: got %b want 0000000", i, outs);
            else n_pass++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (outs !== 7'b0)
                $display("FAIL midrst_busy[%0d]: got %b want 0000000", i, outs);
            else n_pass++;
            tick();
        end
        oob_ready = 1'b1;
        #1;
        n_total++;
        if (outs !== 7'b1000000)
            $display("FAIL midrst_cominit: got %b want 1000000", outs);
        else n_pass++;
        tick();
        tick();
        det_cominit = 1'b1;
        tick();
        det_cominit = 1'b0;
        #1;
        n_total++;
        if (outs !== 7'b0100000)
            $display("FAIL midrst_comwake: got %b want 0100000", outs);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_handshake();
        test_bringup();
        test_timeout();
        test_align_filter();
        test_restart();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sata_oob_ctrl.md
SATA_OOB_CTRL -- requirements
Module: sata_oob_ctrl

Interface
REQ-001 Parameter CLKFREQ, default 100_000, is the clk frequency in kHz.
REQ-002 Parameter TIMEOUT_US, default 880, is the wait-state timeout in microseconds; TMO = CLKFREQ*TIMEOUT_US/1000 cycles, computed with unsigned integer arithmetic and truncated.
REQ-003 clk  input  1  the single clock for the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 restart  input  1  single-cycle request to restart OOB from COMRESET.
REQ-006 oob_ready  input  1  OOB coder ready; a command is accepted in any cycle where this is 1.
REQ-007 oob_cominit  output  1  COMRESET command pulse to the OOB coder.
REQ-008 oob_comwake  output  1  COMWAKE command pulse to the OOB coder.
REQ-009 oob_oobfinish  output  1  ends the OOB phase and enables the transmitter.
REQ-010 det_cominit  input  1  level, high while the OOB detector reports COMINIT from the device.
REQ-011 det_comwake  input  1  level, high while the OOB detector reports COMWAKE from the device.
REQ-012 rx_align  input  1  pulse, an ALIGN primitive was received.
REQ-013 rx_nonalign  input  1  pulse, a non-ALIGN primitive was received.
REQ-014 tx_d102  output  1  transmit the D10.2 pattern.
REQ-015 tx_align  output  1  transmit ALIGN primitives.
REQ-016 linkup  output  1  link is established.
REQ-017 timeout  output  1  one-cycle pulse when a wait state expires.

Function
REQ-018 The FSM states are COMRESET, RST_WAIT, WAIT_INIT, COMWAKE, WAKE_WAIT, WAIT_WAKE, WAIT_ALIGN, SEND_ALIGN and LINKUP.
REQ-019 COMRESET: oob_cominit = oob_ready; when oob_ready=1, go to RST_WAIT on the next cycle.
REQ-020 RST_WAIT: when oob_ready=1 (the coder has finished), go to WAIT_INIT.
REQ-021 WAIT_INIT: when det_cominit=1, go to COMWAKE.
REQ-022 COMWAKE: oob_comwake = oob_ready; when oob_ready=1, go to WAKE_WAIT.
REQ-023 WAKE_WAIT: when oob_ready=1, go to WAIT_WAKE.
REQ-024 WAIT_WAKE: when det_comwake=1, go to WAIT_ALIGN.
REQ-025 WAIT_ALIGN: tx_d102=1 and oob_oobfinish=1; when rx_align=1, go to SEND_ALIGN.
REQ-026 SEND_ALIGN: tx_align=1 and oob_oobfinish=1; go to LINKUP after 3 consecutive rx_nonalign pulses, and any rx_align pulse clears that count.
REQ-027 LINKUP: linkup=1 and oob_oobfinish=1; when det_cominit=1 (device reset), go to COMRESET.
REQ-028 Each command output is high for exactly one cycle per command, and never while oob_ready=0.
REQ-029 All outputs are registered-state decodes, and no output is high outside the states listed for it.
REQ-030 The wait counter is $clog2(TMO+1) bits wide, clears on every state change, and increments in WAIT_INIT, WAIT_WAKE and WAIT_ALIGN without wrapping.
REQ-031 restart=1 forces COMRESET on the next cycle from any state and overrides every other transition.
REQ-032 When a detection and a timeout occur in the same cycle, the detection wins.

Reset
REQ-033 While reset=1, the FSM goes to COMRESET, all counters clear, and every output is 0 on the next edge.
REQ-034 Reset asserted mid-sequence, including while the coder is busy, needs no coder handshake, because COMRESET waits for oob_ready=1.
REQ-035 After reset is released, OOB starts automatically with no start input.

Configuration
REQ-036 The macro is SATA_OOB_CTRL_RETRY_EN.
REQ-037 With SATA_OOB_CTRL_RETRY_EN defined, wait counter = TMO-1 in a wait state pulses timeout for one cycle and moves the FSM to COMRESET.
REQ-038 With SATA_OOB_CTRL_RETRY_EN undefined, no wait counter is built, timeout is tied to 0, and wait states hold indefinitely.

Verification (CLKFREQ=1000, TIMEOUT_US=100, so TMO=100)
REQ-039 Normal bring-up: release reset, run a coder model, det_cominit, det_comwake, rx_align, then 3 rx_nonalign -> one oob_cominit pulse, one oob_comwake pulse, tx_d102 then tx_align, and linkup=1 one cycle after the 3rd rx_nonalign.
REQ-040 Handshake: hold oob_ready=0 for 20 cycles in COMRESET -> oob_cominit stays 0, then pulses once in the first cycle oob_ready=1.
REQ-041 Timeout with RETRY_EN: never assert det_cominit -> timeout pulses in the 100th WAIT_INIT cycle and oob_cominit pulses again; without RETRY_EN -> no pulse after 1000 cycles.
REQ-042 Align filter: in SEND_ALIGN, send nonalign, nonalign, align, nonalign x3 -> linkup only after the final 3rd nonalign.
REQ-043 Override: restart asserted in LINKUP together with rx_align -> linkup=0 and tx_align=0 next cycle, and state is COMRESET.
REQ-044 Mid-operation reset: assert reset in WAIT_ALIGN -> all outputs 0 on the next cycle, and the sequence restarts at COMRESET.
